// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX byte stream among NUM_REQ producers.
// A granted requester keeps the line until newline, burst limit or idle timeout.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned MAX_BURST    = 64,
  parameter bit          LINE_LOCK    = 1'b1,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic [7:0]           o_data,
  output logic                 o_valid,
  input  logic                 i_ready
);

  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam int unsigned IdleW  = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   rr_q, rr_d;
  logic [BurstW-1:0] burst_q, burst_d;
  logic [IdleW-1:0]  idle_q, idle_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;

  logic              pick_found;
  logic [IdxW-1:0]   pick_idx;
  int unsigned       cand;
  logic              owner_valid;
  logic [7:0]        owner_byte;
  logic              out_free;
  logic              xfer;
  logic              release_own;
  logic [IdxW-1:0]   owner_next;

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && i_req_valid[cand[IdxW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IdxW-1:0];
      end
    end
  end

  assign owner_valid = i_req_valid[owner_q];
  assign owner_byte  = i_req_data[8*owner_q +: 8];
  assign out_free    = ~valid_q | i_ready;
  assign xfer        = (state_q == StOwn) & owner_valid & out_free;
  assign owner_next  = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    burst_d     = burst_q;
    idle_d      = idle_q;
    data_d      = data_q;
    valid_d     = valid_q;
    release_own = 1'b0;

    // Output register drains independently of the grant state.
    if (xfer) begin
      data_d  = owner_byte;
      valid_d = 1'b1;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StOwn;
          owner_d = pick_idx;
          burst_d = '0;
          idle_d  = '0;
        end
      end
      StOwn: begin
        idle_d = owner_valid ? '0 : idle_q + 1'b1;
        if (xfer) burst_d = burst_q + 1'b1;
        release_own = (xfer && LINE_LOCK && (owner_byte == 8'h0A)) ||
                      (xfer && (burst_q == BurstW'(MAX_BURST - 1))) ||
                      (!owner_valid && (idle_q == IdleW'(IDLE_TIMEOUT - 1)));
        if (release_own) begin
          state_d = StIdle;
          rr_d    = owner_next;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      rr_q    <= '0;
      burst_q <= '0;
      idle_q  <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    o_grant     = '0;
    o_req_ready = '0;
    if (state_q == StOwn) begin
      o_grant[owner_q]     = 1'b1;
      o_req_ready[owner_q] = out_free;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two requesters, output bytes checked
// against a scoreboard of expected bytes plus grant/ready/latency checks.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  o_req_ready;
  logic [1:0]  o_grant;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready;

  uart_tx_arbiter #(
    .NUM_REQ      (2),
    .MAX_BURST    (4),
    .LINE_LOCK    (1'b1),
    .IDLE_TIMEOUT (16)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (o_req_ready),
    .o_grant     (o_grant),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp_q[$];
  int         out_cyc[$];
  logic [1:0] en;
  int         cyc;
  int         out_cnt;
  int         passes;
  int         fails;
  int         total;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    req_valid[0]  = en[0] && (q0.size() != 0);
    req_data[7:0] = (q0.size() != 0) ? q0[0] : 8'h00;
    req_valid[1]  = en[1] && (q1.size() != 0);
    req_data[15:8] = (q1.size() != 0) ? q1[0] : 8'h00;
  endtask

  // One clock: sample handshakes at negedge, then update requesters after posedge.
  task automatic step();
    logic [1:0] acc;
    @(negedge clk);
    acc = req_valid & o_req_ready;
    if (o_valid === 1'b1 && i_ready === 1'b1) begin
      out_cnt++;
      out_cyc.push_back(cyc);
      total++;
      assert (exp_q.size() != 0) passes++;
      else begin
        fails++;
        $error("FAIL out_unexpected: observed %02h expected none", o_data);
      end
      if (exp_q.size() != 0) check("out_byte", {24'h0, o_data}, {24'h0, exp_q.pop_front()});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    drive();
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_grant != 2'b00) && n < bound) begin
      step();
      n++;
    end
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_released"}, {30'h0, o_grant}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    passes  = 0;
    fails   = 0;
    total   = 0;
    cyc     = 0;
    out_cnt = 0;
    en      = 2'b11;
    i_ready = 1'b1;
    rst_n   = 1'b0;

    // Reset held with both requesters valid, then line-locked transfers.
    q0 = '{8'h41, 8'h42, 8'h0A};
    q1 = '{8'h78, 8'h79, 8'h0A};
    drive();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_valid", {31'h0, o_valid}, 0);
      check("rst_grant", {30'h0, o_grant}, 0);
      check("rst_ready", {30'h0, o_req_ready}, 0);
    end
    exp_q = '{8'h41, 8'h42, 8'h0A, 8'h78, 8'h79, 8'h0A};
    out_cyc.delete();
    rst_n = 1'b1;
    check("idle_grant", {30'h0, o_grant}, 0);
    step();
    check("first_grant", {30'h0, o_grant}, 2'b01);
    check("first_ready", {30'h0, o_req_ready}, 2'b01);
    check("first_valid_lat", {31'h0, o_valid}, 0);
    step();
    check("valid_lat2", {31'h0, o_valid}, 1);
    drain("line", 100);
    check("line_count", out_cyc.size(), 6);
    if (out_cyc.size() == 6) begin
      check("line_gap0", out_cyc[1] - out_cyc[0], 1);
      check("line_gap1", out_cyc[2] - out_cyc[1], 1);
      check("line_bubble", out_cyc[3] - out_cyc[2], 2);
      check("line_gap3", out_cyc[4] - out_cyc[3], 1);
      check("line_gap4", out_cyc[5] - out_cyc[4], 1);
    end

    // Burst limit of 4 alternates groups between requesters.
    for (int i = 0; i < 10; i++) begin
      q0.push_back(8'h10 + 8'(i));
      q1.push_back(8'h20 + 8'(i));
    end
    for (int g = 0; g < 3; g++) begin
      for (int i = 4 * g; i < 4 * g + 4 && i < 10; i++) exp_q.push_back(8'h10 + 8'(i));
      for (int i = 4 * g; i < 4 * g + 4 && i < 10; i++) exp_q.push_back(8'h20 + 8'(i));
    end
    drive();
    drain("burst", 300);

    // Backpressure: output held stable, owner not ready.
    i_ready = 1'b0;
    out_cnt = 0;
    q0 = '{8'h51, 8'h52, 8'h53};
    exp_q = '{8'h51, 8'h52, 8'h53};
    drive();
    step();
    check("bp_grant", {30'h0, o_grant}, 2'b01);
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'h0, o_valid}, 1);
      check("bp_data", {24'h0, o_data}, 8'h51);
      check("bp_ready", {30'h0, o_req_ready}, 0);
      step();
    end
    i_ready = 1'b1;
    drive();
    drain("bp", 100);
    check("bp_count", out_cnt, 3);

    // Idle timeout hands the line to the waiting requester.
    en = 2'b01;
    q0 = '{8'h61};
    q1 = '{8'h71};
    exp_q = '{8'h61, 8'h71};
    drive();
    k = 0;
    while (q0.size() != 0 && k < 10) begin
      step();
      k++;
    end
    en = 2'b11;
    drive();
    k = 0;
    while (o_grant !== 2'b10 && k < 40) begin
      step();
      k++;
    end
    check("timeout_cycles", k, 17);
    drain("timeout", 100);

    // Move the pointer to requester 1, then reset in the middle of its burst.
    q0 = '{8'h0A};
    exp_q = '{8'h0A};
    drive();
    drain("nl", 50);
    i_ready = 1'b0;
    q1 = '{8'h81, 8'h82, 8'h83};
    drive();
    step();
    step();
    check("mid_grant", {30'h0, o_grant}, 2'b10);
    check("mid_valid", {31'h0, o_valid}, 1);
    check("mid_data", {24'h0, o_data}, 8'h81);
    rst_n = 1'b0;
    step();
    check("mid_rst_valid", {31'h0, o_valid}, 0);
    check("mid_rst_grant", {30'h0, o_grant}, 0);
    check("mid_rst_ready", {30'h0, o_req_ready}, 0);
    q0 = '{8'h91};
    exp_q = '{8'h91, 8'h82, 8'h83};
    rst_n = 1'b1;
    i_ready = 1'b1;
    drive();
    step();
    check("post_rst_grant", {30'h0, o_grant}, 2'b01);
    drain("post_rst", 100);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
